// File: rtl/axi_stream_remove_header.sv
// axi_stream_remove_header: strips a 1..BYTE_WD byte header per packet,
// realigns payload to the MSB lane. Define STRIP_ERR_CNT_EN for err_cnt.
module axi_stream_remove_header #(
  parameter  int DATA_WD     = 32,
  localparam int BYTE_WD     = DATA_WD / 8,
  localparam int BYTE_CNT_WD = $clog2(BYTE_WD)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   valid_in,
  input  logic [DATA_WD-1:0]     data_in,
  input  logic [BYTE_WD-1:0]     keep_in,
  input  logic                   last_in,
  output logic                   ready_in,
  input  logic                   valid_strip,
  input  logic [BYTE_CNT_WD-1:0] byte_strip_cnt,
  output logic                   ready_strip,
  output logic                   valid_header,
  output logic [DATA_WD-1:0]     data_header,
  output logic [BYTE_WD-1:0]     keep_header,
  input  logic                   ready_header,
  output logic                   valid_out,
  output logic [DATA_WD-1:0]     data_out,
  output logic [BYTE_WD-1:0]     keep_out,
  output logic                   last_out,
  input  logic                   ready_out
`ifdef STRIP_ERR_CNT_EN
  ,
  output logic [15:0]            err_cnt
`endif
);

  localparam int CW = BYTE_CNT_WD + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] HEAD  = 2'd1;
  localparam logic [1:0] BODY  = 2'd2;
  localparam logic [1:0] FLUSH = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      s_q, s_d;
  logic [CW-1:0]      fl_q, fl_d;
  logic [DATA_WD-1:0] res_q, res_d;
  logic               hv_q, hv_d;
  logic [DATA_WD-1:0] hd_q, hd_d;
  logic [BYTE_WD-1:0] hk_q, hk_d;
  logic               ov_q, ov_d;
  logic [DATA_WD-1:0] od_q, od_d;
  logic [BYTE_WD-1:0] ok_q, ok_d;
  logic               ol_q, ol_d;
  logic               alive_q;
  logic               in_rdy;
  logic               strip_rdy;
`ifdef STRIP_ERR_CNT_EN
  logic               trunc;
`endif

  int                 p_c;
  int                 s_c;
  int                 r_c;
  int                 t_c;
  logic [DATA_WD-1:0] beat_c;
  logic [BYTE_WD-1:0] k_c;

  function automatic logic [BYTE_WD-1:0] lsb_ones(input int n);
    logic [BYTE_WD-1:0] m;
    for (int i = 0; i < BYTE_WD; i++) m[i] = (i < n);
    return m;
  endfunction

  function automatic logic [BYTE_WD-1:0] msb_ones(input int n);
    logic [BYTE_WD-1:0] m;
    for (int i = 0; i < BYTE_WD; i++) m[BYTE_WD-1-i] = (i < n);
    return m;
  endfunction

  function automatic logic [DATA_WD-1:0] expand(input logic [BYTE_WD-1:0] k);
    logic [DATA_WD-1:0] m;
    for (int i = 0; i < BYTE_WD; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  function automatic int popcnt(input logic [BYTE_WD-1:0] k);
    int c;
    c = 0;
    for (int i = 0; i < BYTE_WD; i++) if (k[i]) c++;
    return c;
  endfunction

  // next-state: FSM, residual buffer and both output registers
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    fl_d      = fl_q;
    res_d     = res_q;
    hv_d      = hv_q && !ready_header;
    hd_d      = hd_q;
    hk_d      = hk_q;
    ov_d      = ov_q && !ready_out;
    od_d      = od_q;
    ok_d      = ok_q;
    ol_d      = ol_q;
    in_rdy    = 1'b0;
    strip_rdy = 1'b0;
`ifdef STRIP_ERR_CNT_EN
    trunc     = 1'b0;
`endif
    p_c    = popcnt(keep_in);
    s_c    = int'(s_q);
    r_c    = BYTE_WD - s_c;
    t_c    = r_c + p_c;
    beat_c = (res_q << (8 * s_c)) | (data_in >> (8 * r_c));
    k_c    = '0;
    unique case (state_q)
      IDLE: begin
        strip_rdy = alive_q;
        if (valid_strip && alive_q) begin
          s_d     = CW'(int'(byte_strip_cnt) + 1);
          state_d = HEAD;
        end
      end
      HEAD: begin
        in_rdy = !hv_q || ready_header;
        if (valid_in && in_rdy) begin
          hv_d  = 1'b1;
          res_d = data_in;
          if (last_in && p_c <= s_c) begin
            hd_d    = data_in >> (8 * (BYTE_WD - p_c));
            hk_d    = lsb_ones(p_c);
            state_d = IDLE;
`ifdef STRIP_ERR_CNT_EN
            trunc   = 1'b1;
`endif
          end else begin
            hd_d = data_in >> (8 * r_c);
            hk_d = lsb_ones(s_c);
            if (last_in) begin
              fl_d    = CW'(p_c - s_c);
              state_d = FLUSH;
            end else begin
              state_d = BODY;
            end
          end
        end
      end
      BODY: begin
        in_rdy = !ov_q || ready_out;
        if (valid_in && in_rdy) begin
          ov_d  = 1'b1;
          res_d = data_in;
          od_d  = beat_c;
          ok_d  = '1;
          ol_d  = 1'b0;
          if (last_in) begin
            if (t_c <= BYTE_WD) begin
              k_c     = msb_ones(t_c);
              ok_d    = k_c;
              od_d    = beat_c & expand(k_c);
              ol_d    = 1'b1;
              state_d = IDLE;
            end else begin
              fl_d    = CW'(t_c - BYTE_WD);
              state_d = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        if (!ov_q || ready_out) begin
          k_c     = msb_ones(int'(fl_q));
          ov_d    = 1'b1;
          od_d    = (res_q << (8 * s_c)) & expand(k_c);
          ok_d    = k_c;
          ol_d    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      s_q     <= '0;
      fl_q    <= '0;
      res_q   <= '0;
      hv_q    <= 1'b0;
      hd_q    <= '0;
      hk_q    <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      ok_q    <= '0;
      ol_q    <= 1'b0;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      fl_q    <= fl_d;
      res_q   <= res_d;
      hv_q    <= hv_d;
      hd_q    <= hd_d;
      hk_q    <= hk_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      ok_q    <= ok_d;
      ol_q    <= ol_d;
      alive_q <= 1'b1;
    end
  end

`ifdef STRIP_ERR_CNT_EN
  logic [15:0] err_q;

  // saturating count of truncated packets
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) err_q <= '0;
    else if (trunc && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
  end

  assign err_cnt = err_q;
`endif

  assign ready_in     = in_rdy;
  assign ready_strip  = strip_rdy;
  assign valid_header = hv_q;
  assign data_header  = hd_q;
  assign keep_header  = hk_q;
  assign valid_out    = ov_q;
  assign data_out     = od_q;
  assign keep_out     = ok_q;
  assign last_out     = ol_q;

endmodule

// File: tb/tb_axi_stream_remove_header.sv
// tb_axi_stream_remove_header: byte-level reference model with
// scoreboard queues for the header and payload channels.
module tb_axi_stream_remove_header;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] data_in = '0;
  logic [3:0]  keep_in = '0;
  logic        last_in = 1'b0;
  logic        ready_in;
  logic        valid_strip = 1'b0;
  logic [1:0]  byte_strip_cnt = '0;
  logic        ready_strip;
  logic        valid_header;
  logic [31:0] data_header;
  logic [3:0]  keep_header;
  logic        ready_header = 1'b0;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out = 1'b0;
`ifdef STRIP_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  axi_stream_remove_header #(.DATA_WD(32)) dut (
    .clk(clk),
    .rstn(rstn),
    .valid_in(valid_in),
    .data_in(data_in),
    .keep_in(keep_in),
    .last_in(last_in),
    .ready_in(ready_in),
    .valid_strip(valid_strip),
    .byte_strip_cnt(byte_strip_cnt),
    .ready_strip(ready_strip),
    .valid_header(valid_header),
    .data_header(data_header),
    .keep_header(keep_header),
    .ready_header(ready_header),
    .valid_out(valid_out),
    .data_out(data_out),
    .keep_out(keep_out),
    .last_out(last_out),
    .ready_out(ready_out)
`ifdef STRIP_ERR_CNT_EN
    ,
    .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  beat_t       hq[$];
  beat_t       pq[$];
  logic [31:0] pd[$];
  logic [3:0]  pk[$];

  int checks = 0;
  int errors = 0;
  int exp_err = 0;
  bit rand_rdy = 0;
  bit hold_hdr = 0;
  bit hold_out = 0;

  function automatic logic [31:0] mask(input logic [3:0] k);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_err();
`ifdef STRIP_ERR_CNT_EN
    chk("err_cnt", {16'h0, err_cnt}, 32'(exp_err));
`endif
  endtask

  // reference: header is the first S bytes of the packet, or all of it
  // when a single-beat packet is no longer than S; the rest is repacked
  task automatic model_pkt(input int s);
    logic [7:0] b[$];
    beat_t      e;
    int         n;
    int         h;
    int         pos;
    bit         tr;
    b = {};
    for (int i = 0; i < pd.size(); i++)
      for (int j = 3; j >= 0; j--)
        if (pk[i][j]) b.push_back(pd[i][8*j +: 8]);
    n  = b.size();
    tr = (pd.size() == 1) && (n <= s);
    h  = tr ? n : s;
    if (tr) exp_err++;
    e = '0;
    for (int i = 0; i < h; i++) begin
      e.d = {e.d[23:0], b[i]};
      e.k[i] = 1'b1;
    end
    hq.push_back(e);
    pos = h;
    if (!tr) begin
      while (pos < n) begin
        e = '0;
        for (int j = 0; j < 4; j++) begin
          if (pos < n) begin
            e.d[8*(3-j) +: 8] = b[pos];
            e.k[3-j] = 1'b1;
            pos++;
          end
        end
        e.l = (pos >= n);
        pq.push_back(e);
      end
    end
  endtask

  task automatic do_strip(input int s);
    int n;
    if (rand_rdy) repeat ($urandom_range(0, 1)) @(negedge clk);
    @(negedge clk);
    valid_strip = 1'b1;
    byte_strip_cnt = 2'(s - 1);
    #1;
    n = 0;
    while (!ready_strip && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 2000) begin
      errors++;
      $display("FAIL strip_timeout got %0d want <2000", n);
    end
    @(posedge clk);
    #1;
    valid_strip = 1'b0;
  endtask

  task automatic do_beat(input logic [31:0] d, input logic [3:0] k,
                         input logic l);
    int n;
    if (rand_rdy) repeat ($urandom_range(0, 1)) @(negedge clk);
    @(negedge clk);
    valid_in = 1'b1;
    data_in  = d;
    keep_in  = k;
    last_in  = l;
    #1;
    n = 0;
    while (!ready_in && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 2000) begin
      errors++;
      $display("FAIL beat_timeout got %0d want <2000", n);
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic drive_beats();
    for (int i = 0; i < pd.size(); i++)
      do_beat(pd[i], pk[i], i == pd.size() - 1);
  endtask

  task automatic send_pkt(input int s);
    model_pkt(s);
    do_strip(s);
    drive_beats();
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((hq.size() != 0 || pq.size() != 0 || valid_out || valid_header)
           && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      errors++;
      $display("FAIL drain_timeout got hq=%0d pq=%0d want 0 0",
               hq.size(), pq.size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      ready_out    = hold_out ? 1'b0 :
                     (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
      ready_header = hold_hdr ? 1'b0 :
                     (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // monitor: pops expectations on each handshake, checks stall stability
  initial begin
    beat_t       e;
    bit          hst;
    bit          ost;
    logic [31:0] hs_d;
    logic [3:0]  hs_k;
    beat_t       os;
    hst = 0;
    ost = 0;
    hs_d = '0;
    hs_k = '0;
    os = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rstn) begin
        hst = 0;
        ost = 0;
      end else begin
        if (hst) begin
          checks++;
          if (!valid_header || data_header !== hs_d || keep_header !== hs_k) begin
            errors++;
            $display("FAIL hdr_hold got v=%b %h/%b want 1 %h/%b",
                     valid_header, data_header, keep_header, hs_d, hs_k);
          end
        end
        if (ost) begin
          checks++;
          if (!valid_out || data_out !== os.d || keep_out !== os.k ||
              last_out !== os.l) begin
            errors++;
            $display("FAIL out_hold got v=%b %h/%b/%b want 1 %h/%b/%b",
                     valid_out, data_out, keep_out, last_out,
                     os.d, os.k, os.l);
          end
        end
        if (valid_header && ready_header) begin
          checks++;
          if (hq.size() == 0) begin
            errors++;
            $display("FAIL hdr_extra got %h/%b want none",
                     data_header, keep_header);
          end else begin
            e = hq.pop_front();
            if ((data_header & mask(keep_header)) !== e.d ||
                keep_header !== e.k) begin
              errors++;
              $display("FAIL header got %h/%b want %h/%b",
                       data_header, keep_header, e.d, e.k);
            end
          end
        end
        if (valid_out && ready_out) begin
          checks++;
          if (pq.size() == 0) begin
            errors++;
            $display("FAIL out_extra got %h/%b/%b want none",
                     data_out, keep_out, last_out);
          end else begin
            e = pq.pop_front();
            if ((data_out & mask(keep_out)) !== e.d || keep_out !== e.k ||
                last_out !== e.l) begin
              errors++;
              $display("FAIL payload got %h/%b/%b want %h/%b/%b",
                       data_out, keep_out, last_out, e.d, e.k, e.l);
            end
          end
        end
        hst  = valid_header && !ready_header;
        hs_d = data_header;
        hs_k = keep_header;
        ost  = valid_out && !ready_out;
        os   = {data_out, keep_out, last_out};
      end
    end
  end

  initial begin
    int          s;
    int          nb;
    int          p;
    logic [3:0]  kk;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid_out", {31'h0, valid_out}, 32'h0);
    chk("rst_valid_header", {31'h0, valid_header}, 32'h0);
    chk("rst_ready_in", {31'h0, ready_in}, 32'h0);
    chk("rst_ready_strip", {31'h0, ready_strip}, 32'h0);
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_keep_out", {28'h0, keep_out}, 32'h0);
    chk("rst_last_out", {31'h0, last_out}, 32'h0);
    chk("rst_data_header", data_header, 32'h0);
    chk_err();
    @(negedge clk);
    rstn = 1'b1;

    pd = {32'hAABBCC00, 32'hAABBCC01, 32'hFFFF1234};
    pk = {4'hF, 4'hF, 4'hC};
    send_pkt(2);
    wait_drain();

    pd = {32'h11223344, 32'h55667788};
    pk = {4'hF, 4'hE};
    send_pkt(1);
    wait_drain();

    pd = {32'hDEADBEEF, 32'h01020304};
    pk = {4'hF, 4'hF};
    send_pkt(4);
    wait_drain();

    chk_err();
    hold_hdr = 1;
    pd = {32'hA1B2C3D4};
    pk = {4'hC};
    send_pkt(3);
    pd = {32'h10203040, 32'h50607080};
    pk = {4'hF, 4'h8};
    model_pkt(2);
    do_strip(2);
    @(negedge clk);
    valid_in = 1'b1;
    data_in  = pd[0];
    keep_in  = pk[0];
    last_in  = 1'b0;
    repeat (4) begin
      #1;
      chk("hdr_stall_ready_in", {31'h0, ready_in}, 32'h0);
      @(negedge clk);
    end
    valid_in = 1'b0;
    hold_hdr = 0;
    drive_beats();
    wait_drain();
    chk_err();

    rand_rdy = 1;
    pd = {32'hAABBCC00, 32'hAABBCC01, 32'hFFFF1234};
    pk = {4'hF, 4'hF, 4'hC};
    repeat (3) send_pkt(2);
    wait_drain();
    rand_rdy = 0;
    repeat (2) @(negedge clk);

    hold_hdr = 1;
    hold_out = 1;
    do_strip(2);
    do_beat(32'h12345678, 4'hF, 1'b0);
    do_beat(32'h9ABCDEF0, 4'hF, 1'b0);
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("midrst_valid_out", {31'h0, valid_out}, 32'h0);
    chk("midrst_valid_header", {31'h0, valid_header}, 32'h0);
    chk("midrst_ready_in", {31'h0, ready_in}, 32'h0);
    chk("midrst_ready_strip", {31'h0, ready_strip}, 32'h0);
    exp_err = 0;
    chk_err();
    @(negedge clk);
    rstn = 1'b1;
    hold_hdr = 0;
    hold_out = 0;
    pd = {32'hAABBCC00, 32'hAABBCC01, 32'hFFFF1234};
    pk = {4'hF, 4'hF, 4'hC};
    send_pkt(2);
    wait_drain();

    rand_rdy = 1;
    repeat (150) begin
      s  = $urandom_range(1, 4);
      nb = $urandom_range(1, 4);
      pd = {};
      pk = {};
      for (int i = 0; i < nb; i++) begin
        pd.push_back($urandom);
        if (i < nb - 1) begin
          pk.push_back(4'hF);
        end else begin
          p  = $urandom_range(1, 4);
          kk = '0;
          for (int j = 0; j < p; j++) kk[3-j] = 1'b1;
          pk.push_back(kk);
        end
      end
      send_pkt(s);
    end
    wait_drain();
    rand_rdy = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("end_ready_strip", {31'h0, ready_strip}, 32'h1);
    chk_err();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
